// File: rtl/scoreboard_if.sv
// ============================================================================
// Module  : scoreboard_if
// Purpose : Decode / unit-ready / writeback / issue signals of the scoreboard.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface scoreboard_if #(
    parameter int REG_WIDTH = 5
);
    logic                      dec_valid;
    logic                      dec_ready;
    logic                      dec_dest;
    logic [REG_WIDTH-1:0]      dec_rd;
    logic [REG_WIDTH-1:0]      dec_rs1;
    logic [REG_WIDTH-1:0]      dec_rs2;
    logic                      dec_has_rd;
    logic                      dec_use_rs1;
    logic                      dec_use_rs2;
    logic                      alu_ready;
    logic                      ls_ready;
    logic                      sb_valid;
    logic                      sb_dest;
    logic [REG_WIDTH-1:0]      sb_rs1;
    logic [REG_WIDTH-1:0]      sb_rs2;
    logic                      wb_valid;
    logic [REG_WIDTH-1:0]      wb_rd;
    logic                      exe_valid;
    logic                      exe_dest;
    logic [REG_WIDTH-1:0]      exe_rd;
    logic [2**REG_WIDTH-1:0]   busy;

    // master = decode / units / register-file side, slave = scoreboard
    modport master (
        output dec_valid, dec_dest, dec_rd, dec_rs1, dec_rs2,
               dec_has_rd, dec_use_rs1, dec_use_rs2,
               alu_ready, ls_ready, wb_valid, wb_rd,
        input  dec_ready, sb_valid, sb_dest, sb_rs1, sb_rs2,
               exe_valid, exe_dest, exe_rd, busy
    );

    modport slave (
        input  dec_valid, dec_dest, dec_rd, dec_rs1, dec_rs2,
               dec_has_rd, dec_use_rs1, dec_use_rs2,
               alu_ready, ls_ready, wb_valid, wb_rd,
        output dec_ready, sb_valid, sb_dest, sb_rs1, sb_rs2,
               exe_valid, exe_dest, exe_rd, busy
    );
endinterface

`default_nettype wire

// File: rtl/scoreboard.sv
// ============================================================================
// Module  : scoreboard
// Purpose : In-order single-issue scoreboard with one-entry buffer and
//           per-register busy bits for RAW/WAW hazard stalls.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module scoreboard #(
    parameter int REG_WIDTH = 5
) (
    input  wire logic    clk,
    input  wire logic    rst,
    scoreboard_if.slave  sb
);
    localparam int NUM_REGS = 2**REG_WIDTH;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic                   buf_dest_q, buf_dest_d;
    logic                   buf_has_rd_q, buf_has_rd_d;
    logic                   buf_use_rs1_q, buf_use_rs1_d;
    logic                   buf_use_rs2_q, buf_use_rs2_d;
    logic [REG_WIDTH-1:0]   buf_rd_q, buf_rd_d;
    logic [REG_WIDTH-1:0]   buf_rs1_q, buf_rs1_d;
    logic [REG_WIDTH-1:0]   buf_rs2_q, buf_rs2_d;
    logic [NUM_REGS-1:0]    busy_q, busy_d;
    logic                   exe_valid_q, exe_valid_d;
    logic                   exe_dest_q, exe_dest_d;
    logic [REG_WIDTH-1:0]   exe_rd_q, exe_rd_d;

    logic w_buf_valid;
    logic w_raw;
    logic w_waw;
    logic w_unit_ready;
    logic w_issue;
    logic w_accept;

    // busy[0] is never set, so x0 operands/destinations never stall
    always_comb begin
        w_buf_valid  = (state_q == ST_HOLD);
        w_raw        = (buf_use_rs1_q && busy_q[buf_rs1_q]) ||
                       (buf_use_rs2_q && busy_q[buf_rs2_q]);
        w_waw        = buf_has_rd_q && busy_q[buf_rd_q];
        w_unit_ready = buf_dest_q ? sb.ls_ready : sb.alu_ready;
        w_issue      = w_buf_valid && !w_raw && !w_waw && w_unit_ready;
        w_accept     = sb.dec_valid && (!w_buf_valid || w_issue);
    end

    always_comb begin
        state_d       = state_q;
        buf_dest_d    = buf_dest_q;
        buf_has_rd_d  = buf_has_rd_q;
        buf_use_rs1_d = buf_use_rs1_q;
        buf_use_rs2_d = buf_use_rs2_q;
        buf_rd_d      = buf_rd_q;
        buf_rs1_d     = buf_rs1_q;
        buf_rs2_d     = buf_rs2_q;

        case (state_q)
            ST_EMPTY: if (w_accept) state_d = ST_HOLD;
            ST_HOLD:  if (w_issue && !w_accept) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase

        if (w_accept) begin
            buf_dest_d    = sb.dec_dest;
            buf_has_rd_d  = sb.dec_has_rd;
            buf_use_rs1_d = sb.dec_use_rs1;
            buf_use_rs2_d = sb.dec_use_rs2;
            buf_rd_d      = sb.dec_rd;
            buf_rs1_d     = sb.dec_rs1;
            buf_rs2_d     = sb.dec_rs2;
        end
    end

    // writeback clear is applied first so a same-register issue set wins
    always_comb begin
        busy_d = busy_q;
        if (sb.wb_valid && (sb.wb_rd != '0)) begin
            busy_d[sb.wb_rd] = 1'b0;
        end
        if (w_issue && buf_has_rd_q && (buf_rd_q != '0)) begin
            busy_d[buf_rd_q] = 1'b1;
        end
    end

    always_comb begin
        exe_valid_d = w_issue;
        exe_dest_d  = w_buf_valid ? buf_dest_q : 1'b0;
        exe_rd_d    = (w_buf_valid && buf_has_rd_q) ? buf_rd_q : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_EMPTY;
            buf_dest_q    <= 1'b0;
            buf_has_rd_q  <= 1'b0;
            buf_use_rs1_q <= 1'b0;
            buf_use_rs2_q <= 1'b0;
            buf_rd_q      <= '0;
            buf_rs1_q     <= '0;
            buf_rs2_q     <= '0;
            busy_q        <= '0;
            exe_valid_q   <= 1'b0;
            exe_dest_q    <= 1'b0;
            exe_rd_q      <= '0;
        end else begin
            state_q       <= state_d;
            buf_dest_q    <= buf_dest_d;
            buf_has_rd_q  <= buf_has_rd_d;
            buf_use_rs1_q <= buf_use_rs1_d;
            buf_use_rs2_q <= buf_use_rs2_d;
            buf_rd_q      <= buf_rd_d;
            buf_rs1_q     <= buf_rs1_d;
            buf_rs2_q     <= buf_rs2_d;
            busy_q        <= busy_d;
            exe_valid_q   <= exe_valid_d;
            exe_dest_q    <= exe_dest_d;
            exe_rd_q      <= exe_rd_d;
        end
    end

    assign sb.dec_ready = !w_buf_valid || w_issue;
    assign sb.sb_valid  = w_issue;
    assign sb.sb_dest   = w_buf_valid ? buf_dest_q : 1'b0;
    assign sb.sb_rs1    = w_buf_valid ? buf_rs1_q : '0;
    assign sb.sb_rs2    = w_buf_valid ? buf_rs2_q : '0;
    assign sb.exe_valid = exe_valid_q;
    assign sb.exe_dest  = exe_dest_q;
    assign sb.exe_rd    = exe_rd_q;
    assign sb.busy      = busy_q;

endmodule

`default_nettype wire
